// File: rtl/dcache_pkg.sv
// Shared constants and state encoding for the direct-mapped data cache.
package dcache_pkg;

    localparam int TAG_W   = 3;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int BLOCK_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE      = 2'd0;
    localparam state_t S_WRITEBACK = 2'd1;
    localparam state_t S_FETCH     = 2'd2;
    localparam state_t S_UPDATE    = 2'd3;

endpackage

// File: rtl/dcache_store.sv
// Line storage for the data cache: valid/dirty bits (async cleared),
// tags and data (never cleared), combinational hit and byte select,
// a byte write port for store hits and a full-line fill port.
module dcache_store
    import dcache_pkg::*;
#(
    parameter int TW = TAG_W,
    parameter int IW = IDX_W,
    parameter int OW = OFF_W,
    parameter int BW = BLOCK_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [IW-1:0] idx_i,
    input  logic [TW-1:0] tag_i,
    input  logic [OW-1:0] off_i,
    input  logic          byte_we_i,
    input  logic [7:0]    byte_wdata_i,
    input  logic          fill_we_i,
    input  logic [BW-1:0] fill_data_i,
    output logic          hit_o,
    output logic          line_dirty_o,
    output logic [TW-1:0] line_tag_o,
    output logic [BW-1:0] line_data_o,
    output logic [7:0]    byte_o
);

    localparam int LINES = 1 << IW;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [BW-1:0]    data_q [LINES];

    // Valid/dirty bookkeeping; a fill always leaves the line clean.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= fill_data_i;
        end else if (byte_we_i) begin
            data_q[idx_i][{off_i, 3'b000} +: 8] <= byte_wdata_i;
        end
    end

    assign hit_o        = valid_q[idx_i] & (tag_q[idx_i] == tag_i);
    assign line_dirty_o = valid_q[idx_i] & dirty_q[idx_i];
    assign line_tag_o   = tag_q[idx_i];
    assign line_data_o  = data_q[idx_i];
    assign byte_o       = data_q[idx_i][{off_i, 3'b000} +: 8];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits are served
// combinationally; misses stall the CPU through BUSYWAIT while the FSM
// writes back a dirty victim, fetches the new block and installs it.
//
// Handshakes: the CPU holds READ/WRITE/ADDRESS/WRITEDATA stable while
// BUSYWAIT is high and the access completes at the first rising edge
// with BUSYWAIT low. Toward memory, MEM_READ/MEM_WRITE stay high for the
// whole transfer and the transfer completes at the rising edge where
// MEM_BUSYWAIT is low; the two requests are never high together.
module data_cache
    import dcache_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic                                      READ,
    input  logic                                      WRITE,
    input  logic [ADDR_W-1:0]                         ADDRESS,
    input  logic [7:0]                                WRITEDATA,
    output logic [7:0]                                READDATA,
    output logic                                      BUSYWAIT,
    output logic                                      MEM_READ,
    output logic                                      MEM_WRITE,
    output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]     MEM_ADDRESS,
    output logic [8*BLOCK_BYTES-1:0]                  MEM_WRITEDATA,
    input  logic [8*BLOCK_BYTES-1:0]                  MEM_READDATA,
    input  logic                                      MEM_BUSYWAIT,
    output state_t                                    DBG_STATE
);

    localparam int OFF_B  = $clog2(BLOCK_BYTES);
    localparam int IDX_B  = $clog2(NUM_BLOCKS);
    localparam int TAG_B  = ADDR_W - IDX_B - OFF_B;
    localparam int LINE_B = 8 * BLOCK_BYTES;

    logic [TAG_B-1:0]  addr_tag;
    logic [IDX_B-1:0]  addr_idx;
    logic [OFF_B-1:0]  addr_off;

    logic              hit;
    logic              line_dirty;
    logic [TAG_B-1:0]  line_tag;
    logic [LINE_B-1:0] line_data;
    logic [7:0]        rd_byte;
    logic              byte_we;
    logic              fill_we;

    state_t            state_q, state_d;
    logic [LINE_B-1:0] fill_q, fill_d;
    logic [7:0]        readdata_q, readdata_d;

    assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_B];
    assign addr_idx = ADDRESS[OFF_B +: IDX_B];
    assign addr_off = ADDRESS[OFF_B-1:0];

    // Store hits only land while idle; the fill happens in UPDATE.
    assign byte_we = (state_q == S_IDLE) & WRITE & hit;
    assign fill_we = (state_q == S_UPDATE);

    dcache_store #(
        .TW (TAG_B),
        .IW (IDX_B),
        .OW (OFF_B),
        .BW (LINE_B)
    ) u_store (
        .clk_i        (CLK),
        .rst_ni       (RESET),
        .idx_i        (addr_idx),
        .tag_i        (addr_tag),
        .off_i        (addr_off),
        .byte_we_i    (byte_we),
        .byte_wdata_i (WRITEDATA),
        .fill_we_i    (fill_we),
        .fill_data_i  (fill_q),
        .hit_o        (hit),
        .line_dirty_o (line_dirty),
        .line_tag_o   (line_tag),
        .line_data_o  (line_data),
        .byte_o       (rd_byte)
    );

    // Miss handling sequence and capture of the fetched block.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            S_IDLE: begin
                if ((READ | WRITE) & ~hit) begin
                    state_d = line_dirty ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                if (!MEM_BUSYWAIT) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = S_UPDATE;
                    fill_d  = MEM_READDATA;
                end
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs decoded from state; the victim address comes
    // from the stored tag so it does not follow ADDRESS.
    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        if (state_q == S_WRITEBACK) begin
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {line_tag, addr_idx};
            MEM_WRITEDATA = line_data;
        end else if (state_q == S_FETCH) begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = {addr_tag, addr_idx};
        end
    end

    // Load data follows the hit byte and otherwise holds its last value.
    always_comb begin
        readdata_d = readdata_q;
        if (READ & hit) readdata_d = rd_byte;
    end

    // State, fetched block and held load byte; reset abandons any transfer.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            fill_q     <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            readdata_q <= readdata_d;
        end
    end

    assign READDATA  = readdata_d;
    assign BUSYWAIT  = (state_q != S_IDLE) | ((READ | WRITE) & ~hit);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a flat-memory reference with a
// per-line cache model predicts stall lengths, load bytes, write-backs
// and fetch addresses; a responder plays the block memory.
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_BUSYWAIT = 1'b0;
    logic [1:0]  DBG_STATE;

    int total = 0;
    int bad   = 0;

    // clock / reset
    always #5 CLK = ~CLK;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .DBG_STATE     (DBG_STATE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory responder: busy for mem_lat cycles, then completes
    logic [31:0] mem_blk [64];
    int          mem_lat = 0;
    int          mem_cnt = 0;

    always @(negedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            if (mem_cnt < mem_lat) begin
                MEM_BUSYWAIT = 1'b1;
                mem_cnt++;
            end else begin
                MEM_BUSYWAIT = 1'b0;
                mem_cnt = 0;
                if (MEM_WRITE) mem_blk[MEM_ADDRESS] = MEM_WRITEDATA;
                else           MEM_READDATA = mem_blk[MEM_ADDRESS];
            end
        end else begin
            MEM_BUSYWAIT = 1'b0;
            mem_cnt = 0;
        end
    end

    // reference model: flat block memory plus per-line cache view
    logic [31:0] exp_mem [64];
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_line  [8];
    logic [7:0]  rd_hold = 8'h00;

    logic        exp_wb_on = 1'b0;
    logic [5:0]  exp_wb_addr = 6'h0;
    logic [31:0] exp_wb_data = 32'h0;
    logic        exp_rd_on = 1'b0;
    logic [5:0]  exp_rd_addr = 6'h0;

    logic [5:0]  last_wb_addr = 6'h3F;
    logic [31:0] last_wb_data = 32'h0;
    logic [5:0]  last_rd_addr = 6'h3F;
    int          mem_act = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        rd_hold = 8'h00;
    endtask

    // compare process: memory-side traffic checked every cycle
    always @(negedge CLK) begin
        if (RESET) begin
            check("mem_exclusive", {31'b0, MEM_READ & MEM_WRITE}, 32'd0);
            if (MEM_READ || MEM_WRITE) mem_act++;
            if (MEM_WRITE) begin
                check("wb_expected", {31'b0, exp_wb_on}, 32'd1);
                check("wb_addr", {26'b0, MEM_ADDRESS}, {26'b0, exp_wb_addr});
                check("wb_data", MEM_WRITEDATA, exp_wb_data);
                last_wb_addr = MEM_ADDRESS;
                last_wb_data = MEM_WRITEDATA;
            end
            if (MEM_READ) begin
                check("rd_expected", {31'b0, exp_rd_on}, 32'd1);
                check("rd_addr", {26'b0, MEM_ADDRESS}, {26'b0, exp_rd_addr});
                last_rd_addr = MEM_ADDRESS;
            end
        end
    end

    // driver: one CPU access, held until BUSYWAIT drops
    task automatic do_access(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                             output logic [7:0] got, output int stalls);
        int  idx;
        int  off;
        logic [2:0] tag;
        bit  hit;
        int  exp_st;
        logic [7:0] exp_b;
        idx = int'(addr[4:2]);
        off = int'(addr[1:0]);
        tag = addr[7:5];
        hit = m_valid[idx] && (m_tag[idx] == tag);
        exp_st = hit ? 0 : (m_dirty[idx] ? 2 * mem_lat + 4 : mem_lat + 3);
        exp_wb_on   = !hit && m_dirty[idx];
        exp_wb_addr = {m_tag[idx], addr[4:2]};
        exp_wb_data = m_line[idx];
        exp_rd_on   = !hit;
        exp_rd_addr = {tag, addr[4:2]};

        @(posedge CLK);
        #1;
        READ = !wr;
        WRITE = wr;
        ADDRESS = addr;
        WRITEDATA = wd;
        stalls = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            stalls++;
            check("readdata_hold", {24'b0, READDATA}, {24'b0, rd_hold});
        end
        if (stalls >= 200) check("busywait_timeout", 32'd1, 32'd0);
        check("stall_cycles", stalls, exp_st);

        if (!hit) begin
            if (m_dirty[idx]) exp_mem[{m_tag[idx], addr[4:2]}] = m_line[idx];
            m_line[idx]  = exp_mem[{tag, addr[4:2]}];
            m_tag[idx]   = tag;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_line[idx][off*8 +: 8] = wd;
            m_dirty[idx] = 1'b1;
            got = rd_hold;
        end else begin
            exp_b = m_line[idx][off*8 +: 8];
            check("readdata", {24'b0, READDATA}, {24'b0, exp_b});
            rd_hold = exp_b;
            got = READDATA;
        end
        exp_wb_on = 1'b0;
        exp_rd_on = 1'b0;
    endtask

    task automatic go_idle();
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [7:0] got;
        int         st;
        int         act0;

        for (int i = 0; i < 64; i++) begin
            mem_blk[i] = {8'(i) + 8'h30, 8'(i) + 8'h20, 8'(i) + 8'h10, 8'(i)};
            exp_mem[i] = {8'(i) + 8'h30, 8'(i) + 8'h20, 8'(i) + 8'h10, 8'(i)};
        end
        mem_blk[9] = 32'hDDCCBBAA;
        exp_mem[9] = 32'hDDCCBBAA;
        for (int i = 0; i < 8; i++) begin
            m_tag[i]  = 3'd0;
            m_line[i] = 32'h0;
        end
        model_reset();

        vecs[0] = '{1'b1, 8'h6B, 8'h77, 0};
        vecs[1] = '{1'b0, 8'h6B, 8'h00, 1};
        vecs[2] = '{1'b1, 8'h8A, 8'h12, 2};
        vecs[3] = '{1'b0, 8'h69, 8'h00, 3};
        vecs[4] = '{1'b0, 8'h0C, 8'h00, 0};
        vecs[5] = '{1'b1, 8'h0D, 8'h99, 1};
        vecs[6] = '{1'b0, 8'h2C, 8'h00, 2};
        vecs[7] = '{1'b0, 8'h0D, 8'h00, 3};
        vecs[8] = '{1'b0, 8'h6B, 8'h00, 1};

        // reset values
        repeat (3) @(negedge CLK);
        check("rst_busywait", {31'b0, BUSYWAIT}, 32'd0);
        check("rst_readdata", {24'b0, READDATA}, 32'd0);
        check("rst_mem_read", {31'b0, MEM_READ}, 32'd0);
        check("rst_mem_write", {31'b0, MEM_WRITE}, 32'd0);
        check("rst_mem_address", {26'b0, MEM_ADDRESS}, 32'd0);
        check("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
        check("rst_state", {30'b0, DBG_STATE}, 32'd0);
        RESET = 1'b1;

        // first read after reset misses and fetches block 0
        mem_lat = 2;
        do_access(1'b0, 8'h00, 8'h00, got, st);
        check("lit_first_fetch_addr", {26'b0, last_rd_addr}, 32'h00);
        check("lit_first_stall", st, 32'd5);
        check("lit_first_byte", {24'b0, got}, 32'h00);

        // cold miss with 5 busy cycles, then a hit in the same line
        mem_lat = 5;
        do_access(1'b0, 8'h25, 8'h00, got, st);
        check("lit_cold_byte", {24'b0, got}, 32'hBB);
        check("lit_cold_stall", st, 32'd8);
        do_access(1'b0, 8'h26, 8'h00, got, st);
        check("lit_hit_byte", {24'b0, got}, 32'hCC);
        check("lit_hit_stall", st, 32'd0);

        // write hit, then read it back, no memory traffic
        act0 = mem_act;
        do_access(1'b1, 8'h24, 8'h5A, got, st);
        check("lit_wr_hit_stall", st, 32'd0);
        do_access(1'b0, 8'h24, 8'h00, got, st);
        check("lit_wr_readback", {24'b0, got}, 32'h5A);
        check("no_mem_on_hits", mem_act, act0);

        // dirty eviction of line 1
        mem_lat = 3;
        do_access(1'b0, 8'h44, 8'h00, got, st);
        check("lit_evict_addr", {26'b0, last_wb_addr}, 32'h09);
        check("lit_evict_data", last_wb_data, 32'hDDCCBB5A);
        check("lit_refill_addr", {26'b0, last_rd_addr}, 32'h11);
        check("lit_evict_stall", st, 32'd10);
        check("lit_refill_byte", {24'b0, got}, 32'h11);

        // back-to-back hits on all offsets of the refilled line
        for (int k = 0; k < 4; k++) begin
            do_access(1'b0, 8'h44 + 8'(k), 8'h00, got, st);
            check("b2b_stall", st, 32'd0);
            check("b2b_byte", {24'b0, got}, {24'b0, 8'h11 + 8'(k) * 8'h10});
        end

        // mixed directed vectors across lines and latencies
        for (int v = 0; v < 9; v++) begin
            mem_lat = vecs[v].lat;
            do_access(vecs[v].wr, vecs[v].addr, vecs[v].data, got, st);
        end
        check("lit_wb_roundtrip", {24'b0, got}, 32'h77);

        // reset while a fetch is stalled by memory
        go_idle();
        mem_lat = 6;
        exp_rd_on = 1'b1;
        exp_rd_addr = 6'h39;
        @(posedge CLK);
        #1;
        READ = 1'b1;
        ADDRESS = 8'hE4;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (MEM_READ) break;
        end
        check("fetch_started", {31'b0, MEM_READ}, 32'd1);
        @(negedge CLK);
        check("fetch_stalled", {31'b0, MEM_BUSYWAIT}, 32'd1);
        #2;
        RESET = 1'b0;
        READ = 1'b0;
        #1;
        check("rst_mid_mem_read", {31'b0, MEM_READ}, 32'd0);
        check("rst_mid_busywait", {31'b0, BUSYWAIT}, 32'd0);
        check("rst_mid_state", {30'b0, DBG_STATE}, 32'd0);
        check("rst_mid_readdata", {24'b0, READDATA}, 32'd0);
        model_reset();
        exp_rd_on = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;

        // previously valid lines now miss
        mem_lat = 1;
        do_access(1'b0, 8'h6B, 8'h00, got, st);
        check("lit_post_rst_stall", st, 32'd4);
        do_access(1'b0, 8'h00, 8'h00, got, st);
        check("lit_post_rst_addr0", {26'b0, last_rd_addr}, 32'h00);
        go_idle();
        repeat (2) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
